lfsr_prbs_engine: RTL and testbench

//  Parametrised Galois LFSR PRBS engine: a generator with a valid/ready output

---
 rtl/lfsr_prbs_pkg.sv | 35 +++
 rtl/lfsr_multistep.sv | 28 ++
 rtl/lfsr_prbs_engine.sv | 154 +++++++++++++++
 tb/tb_lfsr_prbs_engine.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_prbs_pkg.sv
// Shared definitions for the PRBS engine.
//   DEFAULT_POLY / DEFAULT_SEED : 26-bit defaults carried over from the old fixed LFSR
//   chk_state_e                 : checker FSM encoding
//   lfsr_step()                 : one Galois step over a WIDTH-bit state held in a
//                                 LFSR_MAX_W container (upper bits ignored / returned 0)
package lfsr_prbs_pkg;

  localparam int          LFSR_MAX_W   = 64;
  localparam logic [25:0] DEFAULT_POLY = 26'h182;
  localparam logic [25:0] DEFAULT_SEED = 26'h1;

  typedef enum logic [1:0] {
    CHK_IDLE = 2'd0,
    CHK_RUN  = 2'd1,
    CHK_LOST = 2'd2
  } chk_state_e;

  // fb is the MSB; it wraps into bit 0 unconditionally and is XORed into every
  // stage whose POLY bit is set.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] poly,
    input int                    width
  );
    logic [LFSR_MAX_W-1:0] n;
    logic                  fb;
    fb   = s[width-1];
    n    = '0;
    n[0] = fb;
    for (int i = 1; i < LFSR_MAX_W; i++)
      if (i < width) n[i] = s[i-1] ^ (poly[i] & fb);
    return n;
  endfunction

endpackage

// File: rtl/lfsr_multistep.sv
// Combinational STEPS-deep unroll of the Galois LFSR step.
//   state_in  : current state
//   state_out : state after STEPS steps
//   bits_out  : emitted bits, bit k = MSB of the state before step k (bit 0 first in time)
module lfsr_multistep
  import lfsr_prbs_pkg::*;
#(
  parameter int               WIDTH = 26,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY),
  parameter int               STEPS = 1
) (
  input  logic [WIDTH-1:0] state_in,
  output logic [WIDTH-1:0] state_out,
  output logic [STEPS-1:0] bits_out
);

  logic [STEPS:0][WIDTH-1:0] chain;

  assign chain[0] = state_in;

  for (genvar k = 0; k < STEPS; k++) begin : g_step
    assign bits_out[k]  = chain[k][WIDTH-1];
    assign chain[k+1]   = WIDTH'(lfsr_step(LFSR_MAX_W'(chain[k]), LFSR_MAX_W'(POLY), WIDTH));
  end

  assign state_out = chain[STEPS];

endmodule

// File: rtl/lfsr_prbs_engine.sv
// PRBS generator + matched checker built on a parametrised Galois LFSR.
// Generator:
//   gen_en/gen_valid  : valid follows enable one cycle later
//   gen_ready         : sink ready; a transfer advances the state STEPS steps
//   gen_load/gen_din  : parallel load (zero loads SEED), wins over advance
//   gen_dout          : STEPS-bit word, bit 0 first in time (combinational from state)
//   gen_state         : current generator state
// Checker:
//   chk_start/chk_seed: (re)start into RUN from seed (zero -> SEED)
//   chk_valid/chk_data: received word, no backpressure
//   chk_locked/lost   : FSM in RUN / LOST
//   chk_err           : one-cycle flag after an errored word
//   chk_err_cnt       : saturating count of errored bits
// clk, rst_n        : clock, synchronous active-low reset
module lfsr_prbs_engine
  import lfsr_prbs_pkg::*;
#(
  parameter int               WIDTH      = 26,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(DEFAULT_POLY),
  parameter logic [WIDTH-1:0] SEED       = WIDTH'(DEFAULT_SEED),
  parameter int               STEPS      = 1,
  parameter int               LOST_WORDS = 4,
  parameter int               ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gen_en,
  input  logic             gen_load,
  input  logic [WIDTH-1:0] gen_din,
  output logic             gen_valid,
  input  logic             gen_ready,
  output logic [STEPS-1:0] gen_dout,
  output logic [WIDTH-1:0] gen_state,
  input  logic             chk_start,
  input  logic [WIDTH-1:0] chk_seed,
  input  logic             chk_valid,
  input  logic [STEPS-1:0] chk_data,
  output logic             chk_locked,
  output logic             chk_lost,
  output logic             chk_err,
  output logic [ERR_W-1:0] chk_err_cnt
);

  localparam int EW = $clog2(STEPS + 1);
  localparam int BW = $clog2(LOST_WORDS + 1);

  // ---------------- generator ----------------
  logic [WIDTH-1:0] gen_state_q, gen_next;
  logic             gen_valid_q;

  lfsr_multistep #(.WIDTH(WIDTH), .POLY(POLY), .STEPS(STEPS)) u_gen_step (
    .state_in  (gen_state_q),
    .state_out (gen_next),
    .bits_out  (gen_dout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gen_state_q <= SEED;
      gen_valid_q <= 1'b0;
    end else begin
      gen_valid_q <= gen_en;
      if (gen_load)
        gen_state_q <= (gen_din == '0) ? SEED : gen_din;
      else if (gen_state_q == '0)        // lock-up state (upset): recover
        gen_state_q <= SEED;
      else if (gen_valid_q && gen_ready)
        gen_state_q <= gen_next;
    end
  end

  assign gen_valid = gen_valid_q;
  assign gen_state = gen_state_q;

  // ---------------- checker ----------------
  chk_state_e       st_q, st_d;
  logic [WIDTH-1:0] chk_lfsr_q, chk_lfsr_d, chk_next;
  logic [STEPS-1:0] chk_exp;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [BW-1:0]    bad_q, bad_d;
  logic [EW-1:0]    err_bits;
  logic [ERR_W:0]   cnt_sum;

  lfsr_multistep #(.WIDTH(WIDTH), .POLY(POLY), .STEPS(STEPS)) u_chk_step (
    .state_in  (chk_lfsr_q),
    .state_out (chk_next),
    .bits_out  (chk_exp)
  );

  always_comb begin
    err_bits = '0;
    for (int k = 0; k < STEPS; k++)
      err_bits = err_bits + EW'(chk_data[k] ^ chk_exp[k]);
  end

  // one spare bit catches the carry out for saturation
  assign cnt_sum = {1'b0, cnt_q} + (ERR_W+1)'(err_bits);

  always_comb begin
    st_d       = st_q;
    chk_lfsr_d = chk_lfsr_q;
    cnt_d      = cnt_q;
    bad_d      = bad_q;
    err_d      = 1'b0;
    if (chk_start) begin
      st_d       = CHK_RUN;
      chk_lfsr_d = (chk_seed == '0) ? SEED : chk_seed;
      cnt_d      = '0;
      bad_d      = '0;
    end else begin
      case (st_q)
        CHK_RUN: begin
          if (chk_lfsr_q == '0) begin
            chk_lfsr_d = SEED;
          end else if (chk_valid) begin
            chk_lfsr_d = chk_next;
            cnt_d      = cnt_sum[ERR_W] ? '1 : cnt_sum[ERR_W-1:0];
            err_d      = (err_bits != '0);
            if (err_bits != '0) begin
              bad_d = bad_q + BW'(1);
              if (bad_q == BW'(LOST_WORDS - 1)) st_d = CHK_LOST;
            end else begin
              bad_d = '0;
            end
          end
        end
        default: ;  // IDLE and LOST ignore traffic
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q       <= CHK_IDLE;
      chk_lfsr_q <= SEED;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      bad_q      <= '0;
    end else begin
      st_q       <= st_d;
      chk_lfsr_q <= chk_lfsr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      bad_q      <= bad_d;
    end
  end

  assign chk_locked  = (st_q == CHK_RUN);
  assign chk_lost    = (st_q == CHK_LOST);
  assign chk_err     = err_q;
  assign chk_err_cnt = cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_engine.sv
// Bench for lfsr_prbs_engine: a STEPS=1 instance for generator behaviour and a
// STEPS=8 instance looped back into its own checker. Stimulus pushes expected
// outputs into queues; a negedge monitor pops and compares.
module tb_lfsr_prbs_engine;

  localparam logic [25:0] POLY = 26'h182;
  localparam logic [25:0] SEED = 26'h1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // STEPS=1 instance
  logic        g1_en, g1_load, g1_valid, g1_ready;
  logic [25:0] g1_din, g1_state, c1_seed;
  logic [0:0]  g1_dout, c1_data;
  logic        c1_start, c1_valid, c1_locked, c1_lost, c1_err;
  logic [15:0] c1_cnt;

  // STEPS=8 instance
  logic        g8_en, g8_load, g8_valid, g8_ready;
  logic [25:0] g8_din, g8_state, c8_seed;
  logic [7:0]  g8_dout, c8_data;
  logic        c8_start, c8_valid, c8_locked, c8_lost, c8_err;
  logic [15:0] c8_cnt;
  logic        inj;
  logic [7:0]  inj_d, flip;

  assign c8_valid = inj | (g8_valid & g8_ready);
  assign c8_data  = inj ? inj_d : (g8_dout ^ flip);

  lfsr_prbs_engine #(.WIDTH(26), .POLY(POLY), .SEED(SEED), .STEPS(1),
                     .LOST_WORDS(4), .ERR_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .gen_en(g1_en), .gen_load(g1_load), .gen_din(g1_din),
    .gen_valid(g1_valid), .gen_ready(g1_ready), .gen_dout(g1_dout), .gen_state(g1_state),
    .chk_start(c1_start), .chk_seed(c1_seed), .chk_valid(c1_valid), .chk_data(c1_data),
    .chk_locked(c1_locked), .chk_lost(c1_lost), .chk_err(c1_err), .chk_err_cnt(c1_cnt)
  );

  lfsr_prbs_engine #(.WIDTH(26), .POLY(POLY), .SEED(SEED), .STEPS(8),
                     .LOST_WORDS(4), .ERR_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .gen_en(g8_en), .gen_load(g8_load), .gen_din(g8_din),
    .gen_valid(g8_valid), .gen_ready(g8_ready), .gen_dout(g8_dout), .gen_state(g8_state),
    .chk_start(c8_start), .chk_seed(c8_seed), .chk_valid(c8_valid), .chk_data(c8_data),
    .chk_locked(c8_locked), .chk_lost(c8_lost), .chk_err(c8_err), .chk_err_cnt(c8_cnt)
  );

  typedef struct { logic [25:0] st; logic [7:0] d; } gexp_t;
  typedef struct { logic lk; logic ls; logic er; logic [15:0] cnt; } cexp_t;
  gexp_t q1[$], q8[$];
  cexp_t qc[$];

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s actual=output-present expected=no-output @%0t", name, $time);
  endtask

  // reference: shift left, fold fb back in through POLY plus the implicit tap at bit 0
  function automatic logic [25:0] m_step(input logic [25:0] s);
    return {s[24:0], 1'b0} ^ (s[25] ? (POLY | 26'h1) : 26'h0);
  endfunction

  function automatic logic [7:0] m_word8(input logic [25:0] s);
    logic [7:0] w;
    for (int k = 0; k < 8; k++) begin
      w[k] = s[25];
      s    = m_step(s);
    end
    return w;
  endfunction

  function automatic logic [25:0] m_adv8(input logic [25:0] s);
    for (int k = 0; k < 8; k++) s = m_step(s);
    return s;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    gexp_t g;
    cexp_t c;
    if (g1_valid) begin
      if (q1.size() == 0) unexpected("g1_word");
      else begin
        g = q1.pop_front();
        check("g1_state", 32'(g1_state), 32'(g.st));
        check("g1_dout", 32'(g1_dout), 32'(g.d[0]));
      end
    end
    if (g8_valid) begin
      if (q8.size() == 0) unexpected("g8_word");
      else begin
        g = q8.pop_front();
        check("g8_state", 32'(g8_state), 32'(g.st));
        check("g8_dout", 32'(g8_dout), 32'(g.d));
      end
    end
    if (qc.size() != 0) begin
      c = qc.pop_front();
      check("c8_locked", 32'(c8_locked), 32'(c.lk));
      check("c8_lost", 32'(c8_lost), 32'(c.ls));
      check("c8_err", 32'(c8_err), 32'(c.er));
      check("c8_cnt", 32'(c8_cnt), 32'(c.cnt));
    end
  end

  // ---------------- models ----------------
  logic [25:0] m1_state = SEED, m8_state = SEED;
  logic        m1_valid = 1'b0, m8_valid = 1'b0;
  logic        e_lk = 1'b0, e_ls = 1'b0, e_er = 1'b0;
  logic [15:0] e_cnt = 16'h0;
  int          e_bad = 0;

  // entry/exit at posedge+1; outputs reflect the current cycle
  task automatic cycle1(input logic en, input logic rdy, input logic ld, input logic [25:0] din,
                        input logic hand, input logic [25:0] h_st, input logic h_d);
    gexp_t g;
    if (m1_valid) begin
      if (hand) begin g.st = h_st;     g.d = {7'b0, h_d}; end
      else      begin g.st = m1_state; g.d = {7'b0, m1_state[25]}; end
      q1.push_back(g);
    end
    g1_en = en; g1_ready = rdy; g1_load = ld; g1_din = din;
    if (ld)                   m1_state = (din == 26'h0) ? SEED : din;
    else if (m1_valid && rdy) m1_state = m_step(m1_state);
    m1_valid = en;
    @(posedge clk); #1;
  endtask

  task automatic cycle8(input logic en, input logic rdy, input logic start, input logic [25:0] seed,
                        input logic i_inj, input logic [7:0] i_d, input logic [7:0] mask,
                        input logic rst);
    gexp_t g;
    cexp_t c;
    int    ne;
    if (m8_valid) begin
      g.st = m8_state; g.d = m_word8(m8_state);
      q8.push_back(g);
    end
    c.lk = e_lk; c.ls = e_ls; c.er = e_er; c.cnt = e_cnt;
    qc.push_back(c);
    g8_en = en; g8_ready = rdy; c8_start = start; c8_seed = seed;
    inj = i_inj; inj_d = i_d; flip = mask; rst_n = !rst;
    if (rst) begin
      m8_state = SEED; m8_valid = 1'b0; m1_state = SEED; m1_valid = 1'b0;
      e_lk = 1'b0; e_ls = 1'b0; e_er = 1'b0; e_cnt = 16'h0; e_bad = 0;
    end else begin
      if (start) begin
        e_lk = 1'b1; e_ls = 1'b0; e_er = 1'b0; e_cnt = 16'h0; e_bad = 0;
      end else if (e_lk && (m8_valid && rdy)) begin
        ne    = $countones(mask);
        e_er  = (ne != 0);
        e_cnt = (int'(e_cnt) + ne > 65535) ? 16'hFFFF : e_cnt + 16'(ne);
        if (ne != 0) begin
          e_bad++;
          if (e_bad == 4) begin e_lk = 1'b0; e_ls = 1'b1; end
        end else e_bad = 0;
      end else e_er = 1'b0;
      if (m8_valid && rdy) m8_state = m_adv8(m8_state);
      m8_valid = en;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    g1_en = 0; g1_load = 0; g1_din = '0; g1_ready = 0;
    c1_start = 0; c1_seed = '0; c1_valid = 0; c1_data = '0;
    g8_en = 0; g8_load = 0; g8_din = '0; g8_ready = 0;
    c8_start = 0; c8_seed = '0; inj = 0; inj_d = '0; flip = '0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    check("rst_g1_valid", 32'(g1_valid), 32'h0);
    check("rst_g1_state", 32'(g1_state), 32'(SEED));
    check("rst_c1_locked", 32'(c1_locked), 32'h0);
    check("rst_c1_lost", 32'(c1_lost), 32'h0);
    check("rst_c1_err", 32'(c1_err), 32'h0);
    check("rst_c1_cnt", 32'(c1_cnt), 32'h0);
    check("rst_g8_valid", 32'(g8_valid), 32'h0);
    check("rst_g8_state", 32'(g8_state), 32'(SEED));
    check("rst_c8_locked", 32'(c8_locked), 32'h0);
    check("rst_c8_lost", 32'(c8_lost), 32'h0);
    check("rst_c8_err", 32'(c8_err), 32'h0);
    check("rst_c8_cnt", 32'(c8_cnt), 32'h0);

    // ---- STEPS=1 generator ----
    cycle1(1, 1, 0, '0, 0, '0, 0);                       // valid rises
    for (int k = 0; k < 26; k++)                          // seed walks up; first 1 on 26th word
      cycle1(1, 1, 0, '0, 1, 26'd1 << k, (k == 25));
    cycle1(1, 1, 0, '0, 1, 26'h183, 0);                   // first feedback step
    cycle1(1, 1, 1, 26'h0, 0, '0, 0);                     // load 0 -> SEED
    cycle1(1, 1, 1, 26'h3FFFFFF, 1, SEED, 0);             // SEED visible; load all-ones
    cycle1(1, 1, 0, '0, 1, 26'h3FFFFFF, 1);
    repeat (3) cycle1(1, 1, 0, '0, 0, '0, 0);
    repeat (5) cycle1(1, 0, 0, '0, 0, '0, 0);             // backpressure: hold
    repeat (5) cycle1(1, 1, 0, '0, 0, '0, 0);
    cycle1(1, 0, 1, 26'h2AAAAAA, 0, '0, 0);               // load under backpressure
    cycle1(1, 1, 0, '0, 1, 26'h2AAAAAA, 1);
    cycle1(0, 1, 0, '0, 0, '0, 0);                        // enable drops
    cycle1(0, 1, 0, '0, 0, '0, 0);
    cycle1(1, 1, 0, '0, 0, '0, 0);
    repeat (3) cycle1(1, 1, 0, '0, 0, '0, 0);
    cycle1(0, 0, 0, '0, 0, '0, 0);
    cycle1(0, 0, 0, '0, 0, '0, 0);

    // ---- STEPS=8 loopback ----
    repeat (2) cycle8(0, 0, 0, '0, 1, 8'hFF, 8'h00, 0);   // IDLE ignores words
    cycle8(1, 0, 1, 26'h0, 1, 8'hFF, 8'h00, 0);           // start (seed 0), same-cycle word ignored
    repeat (1000) cycle8(1, 1, 0, '0, 0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 12; i++)
      cycle8(1, 1, 0, '0, 0, 8'h00, (i == 2) ? 8'h01 : (i == 6) ? 8'h10 : (i == 10) ? 8'h80 : 8'h00, 0);
    repeat (4) cycle8(1, 1, 0, '0, 0, 8'h00, 8'h04, 0);   // -> LOST
    repeat (3) cycle8(1, 1, 0, '0, 0, 8'h00, 8'h3C, 0);   // ignored in LOST
    repeat (2) cycle8(1, 1, 0, '0, 0, 8'h00, 8'h00, 0);
    cycle8(1, 0, 1, m8_state, 0, 8'h00, 8'h00, 0);        // resync restart
    for (int j = 0; j < 11000; j++)                       // 3 bad + 1 clean -> saturation
      cycle8(1, 1, 0, '0, 0, 8'h00, ((j % 4) < 3) ? 8'hFF : 8'h00, 0);
    cycle8(1, 1, 0, '0, 0, 8'h00, 8'h01, 1);              // mid-run reset
    check("mrst_g8_state", 32'(g8_state), 32'(SEED));
    check("mrst_g8_valid", 32'(g8_valid), 32'h0);
    cycle8(0, 0, 0, '0, 0, 8'h00, 8'h00, 0);
    cycle8(0, 0, 0, '0, 0, 8'h00, 8'h00, 0);

    @(negedge clk); #1;
    check("q1_drained", 32'(q1.size()), 32'h0);
    check("q8_drained", 32'(q8.size()), 32'h0);
    check("qc_drained", 32'(qc.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
